// File: rtl/ddr4_cmd_responder.sv
// ddr4_cmd_responder: device-side DDR4-style command checker with bank/timing tracking,
// word storage and a CL-deep read pipeline. Optional saturating error counter: DDR4_RSP_ERRCNT_EN.
module ddr4_cmd_responder #(
  parameter int ROW_W  = 8,
  parameter int COL_W  = 4,
  parameter int DATA_W = 8,
  parameter int T_MOD  = 10,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 8,
  parameter int CL     = 4
) (
  input  logic              clk_50mhz,
  input  logic              rst_50mhz,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [1:0]        ba,
  input  logic [ROW_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              init_done,
  output logic [3:0]        bank_open,
  output logic              viol,
  output logic [2:0]        viol_code,
  output logic [7:0]        err_count
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_MRS = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;
  localparam logic [2:0] CMD_PRE = 3'd5;
  localparam logic [2:0] CMD_REF = 3'd6;
  localparam logic [2:0] CMD_ILL = 3'd7;

  localparam int T_MAX1 = (T_MOD > T_RFC) ? T_MOD : T_RFC;
  localparam int T_MAX2 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int NWORDS = 4 << COL_W;

  // Timers load T-1 on entry and leave the wait state when they read 1, so every T must be >= 2.
  // Global: UNINIT (no MRS yet) | MOD_WAIT (tMOD) | READY | REFRESH (tRFC); bank: CLOSED | OPENING | OPEN | CLOSING.
  typedef enum logic [1:0] {G_UNINIT, G_MOD_WAIT, G_READY, G_REFRESH} gstate_e;
  typedef enum logic [1:0] {B_CLOSED, B_OPENING, B_OPEN, B_CLOSING} bstate_e;

  gstate_e           gst_q, gst_d;
  logic [TW-1:0]     gcnt_q, gcnt_d;
  logic              init_done_q, init_done_d;
  bstate_e           bst_q [4];
  bstate_e           bst_d [4];
  logic [TW-1:0]     bcnt_q [4];
  logic [TW-1:0]     bcnt_d [4];
  logic [ROW_W-1:0]  row_q [4];
  logic [ROW_W-1:0]  row_d [4];
  logic              viol_q, viol_d;
  logic [2:0]        code_q, code_d;
  logic [CL-1:0]     rv_q, rv_d;
  logic [DATA_W-1:0] rdat_q [CL];
  logic [DATA_W-1:0] rdat_d [CL];
  logic [DATA_W-1:0] mem_q [NWORDS];

  logic [COL_W+1:0]  widx;
  bstate_e           sel_st;
  logic              any_busy, acc;
  logic              mrs_acc, act_acc, rd_acc, wr_acc, pre_acc, ref_acc;
  logic              unused_rows;

  assign widx        = {ba, addr[COL_W-1:0]};
  assign unused_rows = ^{row_q[0], row_q[1], row_q[2], row_q[3]};

  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) begin
      gst_q       <= G_UNINIT;
      gcnt_q      <= '0;
      init_done_q <= 1'b0;
      viol_q      <= 1'b0;
      code_q      <= 3'd0;
      rv_q        <= '0;
      for (int b = 0; b < 4; b++) begin
        bst_q[b]  <= B_CLOSED;
        bcnt_q[b] <= '0;
        row_q[b]  <= '0;
      end
      for (int i = 0; i < CL; i++) rdat_q[i] <= '0;
    end else begin
      gst_q       <= gst_d;
      gcnt_q      <= gcnt_d;
      init_done_q <= init_done_d;
      viol_q      <= viol_d;
      code_q      <= code_d;
      rv_q        <= rv_d;
      for (int b = 0; b < 4; b++) begin
        bst_q[b]  <= bst_d[b];
        bcnt_q[b] <= bcnt_d[b];
        row_q[b]  <= row_d[b];
      end
      for (int i = 0; i < CL; i++) rdat_q[i] <= rdat_d[i];
    end
  end

  always_comb begin
    any_busy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (bst_q[b] != B_CLOSED) any_busy = 1'b1;
    end
    sel_st = bst_q[ba];
    code_d = 3'd0;
    if (cmd_valid && cmd != CMD_NOP) begin
      if (gst_q == G_UNINIT && cmd != CMD_MRS)                   code_d = 3'd1;
      else if (gst_q == G_MOD_WAIT || gst_q == G_REFRESH)         code_d = 3'd6;
      else if (cmd == CMD_ILL)                                    code_d = 3'd7;
      else if ((cmd == CMD_MRS || cmd == CMD_REF) && any_busy)    code_d = 3'd5;
      else if (cmd == CMD_ACT && sel_st != B_CLOSED)              code_d = 3'd2;
      else if ((cmd == CMD_RD || cmd == CMD_WR) && sel_st != B_OPEN) code_d = 3'd3;
      else if (cmd == CMD_PRE && sel_st == B_OPENING)             code_d = 3'd4;
    end
    viol_d  = (code_d != 3'd0);
    acc     = cmd_valid && (cmd != CMD_NOP) && !viol_d;
    mrs_acc = acc && (cmd == CMD_MRS);
    act_acc = acc && (cmd == CMD_ACT);
    rd_acc  = acc && (cmd == CMD_RD);
    wr_acc  = acc && (cmd == CMD_WR);
    pre_acc = acc && (cmd == CMD_PRE);
    ref_acc = acc && (cmd == CMD_REF);
  end

  always_comb begin
    gst_d       = gst_q;
    gcnt_d      = gcnt_q;
    init_done_d = init_done_q;
    case (gst_q)
      G_UNINIT: begin
        if (mrs_acc) begin
          gst_d  = G_MOD_WAIT;
          gcnt_d = TW'(T_MOD - 1);
        end
      end
      G_MOD_WAIT: begin
        if (gcnt_q == TW'(1)) begin
          gst_d       = G_READY;
          init_done_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - TW'(1);
        end
      end
      G_READY: begin
        if (mrs_acc) begin
          gst_d  = G_MOD_WAIT;
          gcnt_d = TW'(T_MOD - 1);
        end else if (ref_acc) begin
          gst_d  = G_REFRESH;
          gcnt_d = TW'(T_RFC - 1);
        end
      end
      default: begin
        if (gcnt_q == TW'(1)) gst_d = G_READY;
        else                  gcnt_d = gcnt_q - TW'(1);
      end
    endcase

    for (int b = 0; b < 4; b++) begin
      bst_d[b]  = bst_q[b];
      bcnt_d[b] = bcnt_q[b];
      row_d[b]  = row_q[b];
      case (bst_q[b])
        B_CLOSED: begin
          if (act_acc && ba == 2'(b)) begin
            bst_d[b]  = B_OPENING;
            bcnt_d[b] = TW'(T_RCD - 1);
            row_d[b]  = addr;
          end
        end
        B_OPENING: begin
          if (bcnt_q[b] == TW'(1)) bst_d[b] = B_OPEN;
          else                     bcnt_d[b] = bcnt_q[b] - TW'(1);
        end
        B_OPEN: begin
          if (pre_acc && ba == 2'(b)) begin
            bst_d[b]  = B_CLOSING;
            bcnt_d[b] = TW'(T_RP - 1);
          end
        end
        default: begin
          if (bcnt_q[b] == TW'(1)) bst_d[b] = B_CLOSED;
          else                     bcnt_d[b] = bcnt_q[b] - TW'(1);
        end
      endcase
    end
  end

  // Storage is read at acceptance; each stage only loads when a valid word moves into it,
  // so the last stage (and hence rdata) holds between reads.
  always_comb begin
    rv_d = rv_q;
    for (int i = 0; i < CL; i++) rdat_d[i] = rdat_q[i];
    rv_d[0]   = rd_acc;
    rdat_d[0] = rd_acc ? mem_q[widx] : rdat_q[0];
    for (int i = 1; i < CL; i++) begin
      rv_d[i]   = rv_q[i-1];
      rdat_d[i] = rv_q[i-1] ? rdat_q[i-1] : rdat_q[i];
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (wr_acc) mem_q[widx] <= wdata;
  end

`ifdef DDR4_RSP_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (viol_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) err_cnt_q <= 8'd0;
    else           err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign rdata       = rdat_q[CL-1];
  assign rdata_valid = rv_q[CL-1];
  assign init_done   = init_done_q;
  assign viol        = viol_q;
  assign viol_code   = code_q;

  always_comb begin
    bank_open = 4'b0000;
    for (int b = 0; b < 4; b++) bank_open[b] = (bst_q[b] == B_OPEN);
  end

endmodule

// File: tb/tb_ddr4_cmd_responder.sv
// Scoreboard bench for ddr4_cmd_responder: a timestamp-based model predicts read data and
// violations into queues that a negedge monitor drains; state outputs are checked each cycle.
module tb_ddr4_cmd_responder;

  localparam int ROW_W = 8, COL_W = 4, DATA_W = 8;
  localparam int T_MOD = 10, T_RCD = 3, T_RP = 3, T_RFC = 8, CL = 4;
  localparam logic [2:0] NOP = 3'd0, MRS = 3'd1, ACT = 3'd2, RD = 3'd3,
                         WR = 3'd4, PRE = 3'd5, REF = 3'd6, ILL = 3'd7;

  logic              clk_50mhz = 1'b0;
  logic              rst_50mhz = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [2:0]        cmd = 3'd0;
  logic [1:0]        ba = 2'd0;
  logic [ROW_W-1:0]  addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid, init_done, viol;
  logic [3:0]        bank_open;
  logic [2:0]        viol_code;
  logic [7:0]        err_count;

  ddr4_cmd_responder dut (
    .clk_50mhz(clk_50mhz), .rst_50mhz(rst_50mhz), .cmd_valid(cmd_valid), .cmd(cmd),
    .ba(ba), .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .init_done(init_done), .bank_open(bank_open), .viol(viol), .viol_code(viol_code),
    .err_count(err_count)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int cyc = 0;
  always @(posedge clk_50mhz) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct { int cyc; logic [7:0] data; bit known; } rd_exp_t;
  typedef struct { int cyc; int code; } v_exp_t;
  rd_exp_t rdq[$];
  v_exp_t  vq[$];

  // Model: timestamps of the last MRS/REF/ACT/PRE instead of explicit state machines.
  bit         m_mrs;
  int         m_busy, m_init_at, nviol, m_last_rd;
  bit         m_open [4];
  int         m_act [4];
  int         m_pre [4];
  logic [7:0] m_mem [64];
  bit         m_known [64];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int bstat(int b, int c);
    if (m_open[b]) return (c >= m_act[b] + T_RCD) ? 2 : 1;
    if (c < m_pre[b] + T_RP) return 3;
    return 0;
  endfunction

  function automatic int exp_err();
`ifdef DDR4_RSP_ERRCNT_EN
    return (nviol > 255) ? 255 : nviol;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mrs = 0; m_busy = 0; m_init_at = -1; nviol = 0; m_last_rd = 0;
    for (int b = 0; b < 4; b++) begin m_open[b] = 0; m_act[b] = -1000; m_pre[b] = -1000; end
    rdq.delete();
    vq.delete();
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd = NOP; ba = 2'd0; addr = '0; wdata = '0;
  endtask

  task automatic check_state(input int c);
    logic [3:0] eb;
    eb = 4'b0;
    for (int b = 0; b < 4; b++) eb[b] = (bstat(b, c) == 2);
    chk(init_done == (m_init_at >= 0 && c >= m_init_at), "init_done", init_done,
        (m_init_at >= 0 && c >= m_init_at));
    chk(bank_open == eb, "bank_open", bank_open, eb);
    chk(err_count == 8'(exp_err()), "err_count", err_count, exp_err());
  endtask

  task automatic issue(input bit v, input logic [2:0] c, input logic [1:0] b,
                       input logic [7:0] a, input logic [7:0] d);
    int now, code, g, s, idx;
    bit any;
    @(posedge clk_50mhz);
    #1;
    now = cyc;
    check_state(now);
    code = 0;
    idx  = int'(b) * (1 << COL_W) + int'(a[COL_W-1:0]);
    if (v && c != NOP) begin
      g = !m_mrs ? 0 : (now < m_busy ? 1 : 2);
      s = bstat(int'(b), now);
      any = 0;
      for (int k = 0; k < 4; k++) if (bstat(k, now) != 0) any = 1;
      if (g == 0 && c != MRS)                    code = 1;
      else if (g == 1)                           code = 6;
      else if (c == ILL)                         code = 7;
      else if ((c == MRS || c == REF) && any)    code = 5;
      else if (c == ACT && s != 0)               code = 2;
      else if ((c == RD || c == WR) && s != 2)   code = 3;
      else if (c == PRE && s == 1)               code = 4;
      if (code != 0) begin
        vq.push_back('{now + 1, code});
        nviol++;
      end else begin
        case (c)
          MRS: begin m_mrs = 1; m_busy = now + T_MOD; if (m_init_at < 0) m_init_at = now + T_MOD; end
          REF: m_busy = now + T_RFC;
          ACT: begin m_open[b] = 1; m_act[b] = now; end
          PRE: if (s == 2) begin m_open[b] = 0; m_pre[b] = now; end
          WR:  begin m_mem[idx] = d; m_known[idx] = 1; end
          RD:  rdq.push_back('{now + CL, m_mem[idx], m_known[idx]});
          default: ;
        endcase
      end
    end
    cmd_valid = v; cmd = c; ba = b; addr = a; wdata = d;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, NOP, 2'd0, 8'd0, 8'd0);
  endtask

  task automatic cmdi(input logic [2:0] c, input logic [1:0] b, input logic [7:0] a,
                      input logic [7:0] d);
    issue(1'b1, c, b, a, d);
  endtask

  task automatic do_reset();
    @(posedge clk_50mhz);
    #1;
    idle();
    #1 rst_50mhz = 1'b1;
    #1;
    chk(rdata_valid == 1'b0, "rst_rdata_valid", rdata_valid, 0);
    chk(rdata == 8'd0, "rst_rdata", rdata, 0);
    chk(viol == 1'b0, "rst_viol", viol, 0);
    chk(init_done == 1'b0, "rst_init_done", init_done, 0);
    chk(bank_open == 4'd0, "rst_bank_open", bank_open, 0);
    chk(err_count == 8'd0, "rst_err_count", err_count, 0);
    model_reset();
    repeat (2) @(posedge clk_50mhz);
    #1 rst_50mhz = 1'b0;
  endtask

  always @(negedge clk_50mhz) begin
    if (!rst_50mhz) begin
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        rd_exp_t r;
        r = rdq.pop_front();
        chk(rdata_valid == 1'b1, "rd_valid_missing", rdata_valid, 1);
        if (r.known) chk(rdata == r.data, "rd_data", rdata, r.data);
        m_last_rd = r.known ? int'(r.data) : -1;
      end else begin
        chk(rdata_valid == 1'b0, "rd_valid_spurious", rdata_valid, 0);
        if (m_last_rd >= 0) chk(int'(rdata) == m_last_rd, "rd_hold", rdata, m_last_rd);
      end
      if (vq.size() > 0 && vq[0].cyc == cyc) begin
        v_exp_t e;
        e = vq.pop_front();
        chk(viol == 1'b1, "viol_missing", viol, 1);
        chk(int'(viol_code) == e.code, "viol_code", viol_code, e.code);
      end else begin
        chk(viol == 1'b0, "viol_spurious", viol, 0);
      end
    end
  end

  initial begin
    int r;
    logic [2:0] c;
    for (int i = 0; i < 64; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    model_reset();
    idle();
    #1;
    chk(rdata_valid == 1'b0 && viol == 1'b0 && init_done == 1'b0 && bank_open == 4'd0,
        "initial_reset_outputs", {rdata_valid, viol, init_done, bank_open}, 0);
    repeat (3) @(posedge clk_50mhz);
    #1 rst_50mhz = 1'b0;

    // Init sequence, write/read, tRCD and tRP edges
    nop(2);
    cmdi(ACT, 2'd0, 8'h00, 8'h00);
    nop(2);
    cmdi(MRS, 2'd0, 8'h00, 8'h00);
    nop(8);
    cmdi(ACT, 2'd0, 8'h00, 8'h00);
    cmdi(ACT, 2'd1, 8'h22, 8'h00);
    nop(1);
    cmdi(RD, 2'd1, 8'h03, 8'h00);
    cmdi(WR, 2'd1, 8'h03, 8'hA5);
    cmdi(RD, 2'd1, 8'h03, 8'h00);
    nop(6);
    cmdi(PRE, 2'd1, 8'h00, 8'h00);
    nop(1);
    cmdi(ACT, 2'd1, 8'h10, 8'h00);
    cmdi(ACT, 2'd1, 8'h10, 8'h00);
    cmdi(ACT, 2'd0, 8'h05, 8'h00);
    nop(3);
    // Refresh windows
    cmdi(REF, 2'd0, 8'h00, 8'h00);
    cmdi(PRE, 2'd0, 8'h00, 8'h00);
    cmdi(PRE, 2'd1, 8'h00, 8'h00);
    nop(2);
    cmdi(REF, 2'd0, 8'h00, 8'h00);
    nop(6);
    cmdi(ACT, 2'd2, 8'h07, 8'h00);
    cmdi(ACT, 2'd2, 8'h07, 8'h00);
    nop(2);
    // Pipelined reads, then a reset with reads in flight
    for (int i = 0; i < 4; i++) cmdi(WR, 2'd2, 8'(i), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) cmdi(RD, 2'd2, 8'(i), 8'h00);
    nop(6);
    for (int i = 0; i < 4; i++) cmdi(RD, 2'd2, 8'(i), 8'h00);
    nop(1);
    do_reset();
    nop(CL + 2);

    // Randomized traffic
    cmdi(MRS, 2'd0, 8'h00, 8'h00);
    nop(T_MOD);
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       c = 3'($urandom_range(0, 7));
      else if (r < 11) c = MRS;
      else if (r < 36) c = ACT;
      else if (r < 56) c = RD;
      else if (r < 72) c = WR;
      else if (r < 90) c = PRE;
      else if (r < 95) c = REF;
      else             c = ILL;
      issue(r >= 8, c, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)));
    end
    nop(CL + 2);

    // Error counter saturation
    do_reset();
    for (int n = 0; n < 300; n++) cmdi(ACT, 2'($urandom_range(0, 3)), 8'h00, 8'h00);
    nop(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_responder.md
# ddr4_cmd_responder

Cycle-based DDR4-style command responder: the device-side counterpart of the memory-controller FSM. It decodes one command per clock from the controller, tracks mode-register initialisation, per-bank open/closed state and the tMOD/tRCD/tRP/tRFC timing windows, stores write data, returns read data after CAS latency, and flags every protocol or timing violation. It sits on the board between the controller and the HEX/LED debug logic, which display its status.

## Interface
- ROW_W, 8: row address width.
- COL_W, 4: column address width; storage is 4 banks x 2^COL_W words.
- DATA_W, 8: data word width.
- T_MOD, 10: MRS-to-any-command cycles.
- T_RCD, 3: ACT-to-RD/WR cycles.
- T_RP, 3: PRE-to-ACT cycles.
- T_RFC, 8: REF-to-any-command cycles.
- CL, 4: RD-to-data cycles, at least 1.

- clk_50mhz  in  1  clock.
- rst_50mhz  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command strobe; low means NOP.
- cmd  in  3  0 NOP, 1 MRS, 2 ACT, 3 RD, 4 WR, 5 PRE, 6 REF, 7 illegal.
- ba  in  2  bank address.
- addr  in  ROW_W  row for ACT; addr[COL_W-1:0] is the column for RD/WR.
- wdata  in  DATA_W  write data, sampled with WR.
- rdata  out  DATA_W  read data.
- rdata_valid  out  1  one-cycle qualifier for rdata.
- init_done  out  1  first MRS and T_MOD are complete.
- bank_open  out  4  per-bank OPEN state.
- viol  out  1  one-cycle pulse on a rejected command.
- viol_code  out  3  reason, valid while viol is high.
- err_count  out  8  saturating violation count.

## Operation
- Global FSM states:
  - UNINIT: reset state. The only legal command is MRS, which goes to MOD_WAIT.
  - MOD_WAIT: counts T_MOD, then goes to READY and sets init_done. init_done stays high until reset.
  - READY: accepts all commands. REF goes to REFRESH. MRS goes to MOD_WAIT.
  - REFRESH: counts T_RFC, then returns to READY.
- Per-bank states:
  - CLOSED: ACT goes to OPENING.
  - OPENING: counts T_RCD, then goes to OPEN.
  - OPEN: holds the latched row. PRE goes to CLOSING.
  - CLOSING: counts T_RP, then goes to CLOSED.
- PRE to a CLOSED bank is a legal no-op.
- RD/WR to an OPEN bank address storage word {ba, col}. The open row checks legality only and does not index storage; rows alias.
- WR writes in the acceptance cycle.
- Violations, checked in priority order:
  - 1: non-NOP command other than MRS while in UNINIT.
  - 6: non-NOP command while in MOD_WAIT or REFRESH.
  - 7: cmd 7.
  - 5: MRS or REF while any bank is not CLOSED.
  - 2: ACT to a non-CLOSED bank.
  - 3: RD/WR to a bank that is not OPEN. This includes OPENING, so it covers tRCD violations.
  - 4: PRE to an OPENING bank.
- A violating command has no effect: no state change, no write, no read issued.
- Reset: all outputs 0, global FSM to UNINIT, all banks CLOSED, read pipeline flushed. Storage is not reset; reads of never-written words return unspecified data.

## Timing
- Every window is defined relative to the acceptance cycle N:
  - MRS at N: init_done is high from N+T_MOD, and a command at N+T_MOD is legal.
  - ACT at N: bank_open[ba] is high from N+T_RCD, and RD/WR at N+T_RCD is legal. RD/WR at N+T_RCD-1 is code 3.
  - PRE at N: ACT to that bank at N+T_RP is legal. At N+T_RP-1 it is code 2.
  - REF at N: a command at N+T_RFC is legal. At N+T_RFC-1 it is code 6.
- Read path:
  - RD accepted at N drives rdata_valid high for exactly cycle N+CL, with rdata valid in that cycle.
  - Back-to-back RDs every cycle are supported through a CL-deep pipeline.
  - rdata holds its last value when rdata_valid is low.
- WR at N followed by RD of the same word at N+1 returns the new data.
- Reads still in flight complete normally across a subsequent PRE/REF/MRS.
- viol and viol_code are registered: a bad command at N pulses them at N+1.
- err_count increments in the same cycle as viol.
- Asynchronous reset mid-operation clears everything immediately, including in-flight reads.

## Configuration
- DDR4_RSP_ERRCNT_EN defined: err_count is an 8-bit counter, +1 per violation, saturating at 255, cleared only by reset.
- DDR4_RSP_ERRCNT_EN undefined: no counter is built and err_count is constant 0. viol and viol_code are unchanged.

## Test plan
- Init sequence: ACT at cycle 2 gives viol/code 1. MRS at 5 gives init_done high from cycle 15. ACT at 14 gives code 6. ACT at 15 is accepted.
- Write/read: ACT ba=1 row=0x22. WR ba=1 col=3 data=0xA5 at ACT+3. RD the same word next cycle. rdata_valid is high exactly CL=4 cycles after RD, with rdata=0xA5.
- tRCD/tRP edges: RD at ACT+2 gives code 3 and no rdata_valid. ACT after PRE at PRE+2 gives code 2. ACT at PRE+3 is accepted.
- Refresh: REF with bank 0 open gives code 5. PRE, wait 3, REF. Any command at REF+7 gives code 6, and at REF+8 it is accepted.
- Pipelined reads: 4 RDs on consecutive cycles to cols 0-3 with data 0x10-0x13 give 4 consecutive rdata_valid cycles in order. Asserting reset mid-stream drops the remaining valids.
- Counter macro: 300 violations give err_count=255 with the macro defined, and err_count=0 without it.
